luna_alu_sequencer: RTL
=======================

Name: luna_alu_sequencer

Overview:
- Initiator-side front end for the registered Luna ALU.
- Accepts one operation at a time on a valid/ready command interface and drives the ALU control and operand inputs.
- Waits a fixed ALU latency, captures the result and status flags, and presents them on a valid/ready response interface.
- Sits between the instruction decode/control path and the ALU; it owns every ALU input and consumes every ALU output.

Parameters:
- ALU_LATENCY, 1: rising edges from ALU operands becoming stable to alu_result/flags being valid; legal range 0..15.
- CNT_W, 16: width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = in reset).
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_x  in  16  operand x.
- cmd_y  in  16  operand y.
- cmd_opcode  in  2  ALU opcode.
- cmd_zero_x  in  1  force x to zero.
- cmd_zero_y  in  1  force y to zero.
- cmd_negate_output  in  1  bitwise-invert ALU result.
- cmd_chain  in  1  use previous result as x (see Optional Feature).
- alu_x  out  16  to ALU x.
- alu_y  out  16  to ALU y.
- alu_opcode  out  2  to ALU opcode.
- alu_zero_x  out  1  to ALU zero_x.
- alu_zero_y  out  1  to ALU zero_y.
- alu_negate_output  out  1  to ALU negate_output.
- alu_result  in  16  from ALU output_result.
- alu_is_zero  in  1  from ALU is_zero.
- alu_is_negative  in  1  from ALU is_negative.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  16  captured result.
- rsp_is_zero  out  1  captured zero flag.
- rsp_is_negative  out  1  captured negative flag.
- busy  out  1  state != IDLE.
- op_count  out  CNT_W  completed responses, wraps at 2^CNT_W.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE.
  - All alu_* outputs, rsp_* outputs, op_count, the latency counter and prev_result = 0; busy = 0.
  - cmd_ready = 1 once IDLE; benches must not send commands while rst=0.
- States: IDLE, WAIT, DONE. cmd_ready = (state == IDLE), combinational from the state register.
- IDLE:
  - On edge E0 with cmd_valid & cmd_ready: register all cmd fields into the alu_* outputs; load latency counter with ALU_LATENCY; go to WAIT.
  - No handshake: alu_* outputs hold their last values.
- WAIT:
  - Counter decrements once per edge.
  - At edge E0+ALU_LATENCY+1: capture alu_result and flags into rsp_*; go to DONE; rsp_valid=1.
  - Command-to-rsp_valid latency is ALU_LATENCY+1 cycles; ALU_LATENCY=0 gives 1 cycle.
  - alu_* outputs stay stable throughout WAIT.
- DONE:
  - rsp_* held stable while rsp_ready=0; cmd_ready=0.
  - On an edge with rsp_ready=1: rsp_valid→0, op_count+1 (wraps 0xFFFF→0), prev_result←rsp_result, go to IDLE.
  - A new command is accepted no earlier than the following edge. Peak throughput: one op per ALU_LATENCY+3 cycles.
- cmd_valid while busy: ignored, not queued. Commanders hold cmd_valid until accepted.
- rsp_result/flags are copied unchanged from the ALU; the sequencer does no arithmetic.
- Reset mid-WAIT or mid-DONE: immediate return to the reset state. No response is emitted, op_count is cleared, and no late capture occurs after release.
- rsp_ready with rsp_valid=0: no effect.

Optional Feature:
- Macro: LUNA_ALU_SEQ_CHAIN_EN.
- Defined:
  - If cmd_chain=1 at accept, alu_x = prev_result instead of cmd_x.
  - prev_result is the last handshaked rsp_result; 0 after reset.
  - All other fields are used as given.
- Undefined: cmd_chain is ignored, prev_result does not exist, and alu_x = cmd_x always.

Test Plan:
- Bench ALU stub: delay ALU_LATENCY edges; opcode 2'h2 → x+y; zero_x/zero_y force the operand to 0; negate_output inverts bitwise; flags are derived from the result.
- Basic add: ALU_LATENCY=1, x=0x0002, y=0x0005, opcode=2, accepted at edge E0 → rsp_valid rises after E0+2; rsp_result=0x0007, is_zero=0, is_negative=0; op_count=1 after rsp handshake.
- Zero/negate: x=10, y=0, zero_x=1 → result 0, is_zero=1. Then x=0, y=0, negate_output=1 → 0xFFFF, is_negative=1, is_zero=0.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid → rsp_* stable, cmd_ready=0, a cmd_valid pulse is ignored, op_count unchanged until the handshake.
- Reset mid-op: assert rst=0 one cycle into WAIT with ALU_LATENCY=3 → all outputs 0 immediately; after release, no rsp_valid ever appears for the aborted op; cmd_ready=1.
- Chain (macro defined): 10+5 → 15, handshake. Then cmd_chain=1, cmd_x=0x1234, y=1 → alu_x=15, result 16. With the macro undefined, the same stimulus gives 0x1235.

Source files
------------

// File: rtl/luna_alu_sequencer.sv
// Command/response front end for the registered Luna ALU: issues one op, waits ALU_LATENCY, returns result.
// Optional build macro LUNA_ALU_SEQ_CHAIN_EN: cmd_chain feeds the previous result into alu_x.
module luna_alu_sequencer #(
    parameter int unsigned ALU_LATENCY = 1,
    parameter int unsigned CNT_W       = 16,
    localparam int unsigned DATA_W     = 16,
    localparam int unsigned OP_W       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_x,
    input  logic [DATA_W-1:0] cmd_y,
    input  logic [OP_W-1:0]   cmd_opcode,
    input  logic              cmd_zero_x,
    input  logic              cmd_zero_y,
    input  logic              cmd_negate_output,
    input  logic              cmd_chain,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    output logic [OP_W-1:0]   alu_opcode,
    output logic              alu_zero_x,
    output logic              alu_zero_y,
    output logic              alu_negate_output,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_is_zero,
    input  logic              alu_is_negative,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_is_zero,
    output logic              rsp_is_negative,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);
    localparam int unsigned LAT_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [LAT_W-1:0]  lat_cnt_q;
    logic              accept_c;
    logic              capture_c;
    logic              release_c;
    logic [DATA_W-1:0] x_sel_c;

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);

`ifdef LUNA_ALU_SEQ_CHAIN_EN
    logic [DATA_W-1:0] prev_result_q;

    assign x_sel_c = cmd_chain ? prev_result_q : cmd_x;

    // Last result handed to the consumer, reused as x by chained commands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_result_q <= '0;
        end else if (release_c) begin
            prev_result_q <= rsp_result;
        end
    end
`else
    logic unused_chain;

    assign unused_chain = cmd_chain;
    assign x_sel_c      = cmd_x;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus single-cycle strobes for the datapath registers.
    always_comb begin
        state_d   = state_q;
        accept_c  = 1'b0;
        capture_c = 1'b0;
        release_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept_c = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_cnt_q == '0) begin
                    capture_c = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    release_c = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ALU drive, latency countdown, response capture and completion count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_x             <= '0;
            alu_y             <= '0;
            alu_opcode        <= '0;
            alu_zero_x        <= 1'b0;
            alu_zero_y        <= 1'b0;
            alu_negate_output <= 1'b0;
            lat_cnt_q         <= '0;
            rsp_valid         <= 1'b0;
            rsp_result        <= '0;
            rsp_is_zero       <= 1'b0;
            rsp_is_negative   <= 1'b0;
            op_count          <= '0;
        end else begin
            if (accept_c) begin
                alu_x             <= x_sel_c;
                alu_y             <= cmd_y;
                alu_opcode        <= cmd_opcode;
                alu_zero_x        <= cmd_zero_x;
                alu_zero_y        <= cmd_zero_y;
                alu_negate_output <= cmd_negate_output;
                lat_cnt_q         <= LAT_W'(ALU_LATENCY);
            end else if ((state_q == ST_WAIT) && (lat_cnt_q != '0)) begin
                lat_cnt_q <= lat_cnt_q - LAT_W'(1);
            end
            if (capture_c) begin
                rsp_valid       <= 1'b1;
                rsp_result      <= alu_result;
                rsp_is_zero     <= alu_is_zero;
                rsp_is_negative <= alu_is_negative;
            end
            if (release_c) begin
                rsp_valid <= 1'b0;
                op_count  <= op_count + CNT_W'(1);
            end
        end
    end

endmodule
